// File: rtl/rom_loader_pkg.sv
// Shared constants and state encoding for the boot-time ROM loader.
package rom_loader_pkg;

  localparam int unsigned WORD_BYTES    = 6;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = WORD_BYTES * BYTE_W;
  localparam int unsigned LEN_W         = 16;
  localparam logic [7:0]  DEFAULT_MAGIC = 8'h5A;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    HOLD,
    RUN,
    ERROR
  } state_t;

endpackage

// File: rtl/rom_word_assembler.sv
// Packs bytes MSB-first into 48-bit instruction words.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   clear         - frame start, drops any partial word
//   shift         - a data byte is transferred this cycle
//   byte_in       - the data byte
//   word_next_c   - word including byte_in (complete when word_ready_c)
//   word_ready_c  - byte_in is the last byte of the current word
module rom_word_assembler
  import rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_next_c,
  output logic              word_ready_c
);

  localparam int unsigned CNT_W  = $clog2(WORD_BYTES);
  localparam int unsigned HEAD_W = WORD_W - BYTE_W;

  // Only the first five bytes need storage; the sixth is taken straight
  // from byte_in so the full word is available on the transfer cycle.
  logic [HEAD_W-1:0] head_q;
  logic [CNT_W-1:0]  idx_q;

  assign word_next_c  = {head_q, byte_in};
  assign word_ready_c = shift && (idx_q == CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head_q <= '0;
      idx_q  <= '0;
    end else if (shift) begin
      head_q <= word_next_c[HEAD_W-1:0];
      idx_q  <= word_ready_c ? '0 : idx_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Boot-time program loader: receives a framed byte stream, writes 48-bit
// words into program ROM from address 0, and releases the CPU from reset
// only after the length and checksum are accepted.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   rx_data/valid/ready   - byte stream handshake
//   rom_addr/data/we      - ROM write port (registered, one-cycle strobe)
//   cpu_reset             - active-high CPU hold
//   done, error           - load succeeded / failed
//   word_count            - words written in the current load
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned MAX_PC      = 2048,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [7:0]  MAGIC       = DEFAULT_MAGIC,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [WORD_W-1:0]     rom_data,
  output logic                  rom_we,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] word_count
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  state_t            state;
  logic [7:0]        len_hi;
  logic [LEN_W-1:0]  len;
  logic [7:0]        acc;
  logic [HOLD_W-1:0] hold_cnt;

  logic                  fire_c;
  logic                  start_c;
  logic                  shift_c;
  logic [LEN_W-1:0]      len_c;
  logic [7:0]            sum_c;
  logic [ADDR_WIDTH-1:0] wc_inc_c;
  logic [WORD_W-1:0]     word_next_c;
  logic                  word_ready_c;

  assign fire_c   = rx_valid && rx_ready;
  // MAGIC only opens a frame from the waiting states.
  assign start_c  = fire_c && (rx_data == MAGIC) &&
                    ((state == IDLE) || (state == RUN) || (state == ERROR));
  assign shift_c  = fire_c && (state == DATA);
  assign len_c    = {len_hi, rx_data};
  assign sum_c    = acc + rx_data;
  assign wc_inc_c = word_count + ADDR_WIDTH'(1);

  rom_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_c),
    .shift        (shift_c),
    .byte_in      (rx_data),
    .word_next_c  (word_next_c),
    .word_ready_c (word_ready_c)
  );

  // Loader FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rx_ready   <= 1'b1;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      acc        <= '0;
      len_hi     <= '0;
      len        <= '0;
      hold_cnt   <= '0;
    end else begin
      rom_we <= 1'b0;
      if (start_c) begin
        state      <= LEN_HI;
        word_count <= '0;
        acc        <= '0;
        cpu_reset  <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
      end else begin
        unique case (state)
          LEN_HI: if (fire_c) begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
          LEN_LO: if (fire_c) begin
            len <= len_c;
            if (len_c > LEN_W'(MAX_PC)) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (len_c == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: if (fire_c) begin
            acc <= sum_c;
            if (word_ready_c) begin
              state    <= WRITE;
              rom_we   <= 1'b1;
              rom_addr <= word_count;
              rom_data <= word_next_c;
              rx_ready <= 1'b0;
            end
          end
          WRITE: begin
            word_count <= wc_inc_c;
            rx_ready   <= 1'b1;
            state      <= (wc_inc_c == ADDR_WIDTH'(len)) ? CSUM : DATA;
          end
          CSUM: if (fire_c) begin
            if (sum_c == 8'h00) begin
              state    <= HOLD;
              hold_cnt <= HOLD_W'(HOLD_CYCLES);
              rx_ready <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
          // Counter hits zero after HOLD_CYCLES edges; release on the next.
          HOLD: begin
            if (hold_cnt == '0) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
              rx_ready  <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
          default: ;  // IDLE, RUN, ERROR: non-MAGIC bytes are discarded
        endcase
      end
    end
  end

endmodule
